if_stage: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register for the 5-stage RISC core. It holds the PC and issues one outstanding request at a time to the instruction memory over a req/valid handshake. It delivers fetched instructions into the IF/ID register. It obeys the hazard unit's PCWrite/IFIDWrite stall controls and the EX-stage branch redirect, and sits directly upstream of decode and of the hazard unit.

---
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register; one outstanding imem request at a time.
// Optional IF_FLUSH_CNT_EN adds a saturating count of branch redirect cycles on flush_count.
module if_stage #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCWrite,
  input  logic               IFIDWrite,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid
`ifdef IF_FLUSH_CNT_EN
 ,output logic [15:0]        flush_count
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  localparam logic [PC_W-1:0] STEP   = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    hold_pc;

  assign imem_req  = (state == S_REQ) && !rst;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= PC_RST;
      hold_instr <= '0;
      hold_pc    <= '0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      pc         <= branch_target;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      case (state)
        S_REQ:  state <= S_DROP;
        S_WAIT: state <= imem_valid ? S_REQ : S_DROP;
        S_HOLD: state <= S_REQ;
        // a stale response landing with the redirect retires the drop
        S_DROP: if (imem_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (IFIDWrite) begin
              ifid_instr <= imem_rdata;
              ifid_pc    <= pc;
              ifid_valid <= 1'b1;
              if (PCWrite) pc <= pc + STEP;
              state <= S_REQ;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= pc;
              state      <= S_HOLD;
            end
          end else if (IFIDWrite) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (IFIDWrite) begin
            ifid_instr <= hold_instr;
            ifid_pc    <= hold_pc;
            ifid_valid <= 1'b1;
            if (PCWrite) pc <= pc + STEP;
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (IFIDWrite) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
          end
          if (imem_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_FLUSH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_count <= '0;
    end else if (branch_taken && (flush_count != '1)) begin
      flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-programmable instruction memory, reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, IFIDWrite, branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_instr, ifid_pc;
  logic        ifid_valid;
`ifdef IF_FLUSH_CNT_EN
  logic [15:0] flush_count;
`endif

  always #5 clk = ~clk;

  if_stage #(.PC_W(16), .INSTR_W(16), .PC_STEP(1), .RESET_PC(16'h0010)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
`ifdef IF_FLUSH_CNT_EN
   ,.flush_count(flush_count)
`endif
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Memory: answers a request sampled mid-cycle after lat cycles with addr ^ 0xA5A5.
  int          lat;
  bit          pend;
  int          cnt;
  logic [15:0] paddr;
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      imem_valid = 1'b0;
      if (rst) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = paddr ^ 16'hA5A5;
          pend = 1'b0;
        end
      end
      @(negedge clk); #1;
      if (!rst && imem_req) begin
        pend = 1'b1;
        cnt = lat;
        paddr = imem_addr;
      end
    end
  end

  // Reference model: request outstanding / response stale / response parked.
  logic        m_out, m_stale, m_held, m_iv;
  logic [15:0] m_pc, m_hi, m_hp, m_ii, m_ip, m_fc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out <= 0; m_stale <= 0; m_held <= 0; m_iv <= 0;
      m_pc <= 16'h0010; m_hi <= 0; m_hp <= 0; m_ii <= 0; m_ip <= 0; m_fc <= 0;
    end else begin
      if (branch_taken && m_fc != 16'hFFFF) m_fc <= m_fc + 1;
      if (branch_taken) begin
        m_pc <= branch_target; m_iv <= 0; m_ii <= 0;
        if (m_held) m_held <= 0;
        else if (!m_out) begin m_out <= 1; m_stale <= 1; end
        else if (imem_valid) begin m_out <= 0; m_stale <= 0; end
        else m_stale <= 1;
      end else if (m_held) begin
        if (IFIDWrite) begin
          m_ii <= m_hi; m_ip <= m_hp; m_iv <= 1; m_held <= 0;
          if (PCWrite) m_pc <= m_pc + 1;
        end
      end else if (!m_out) begin
        m_out <= 1;
      end else if (m_stale) begin
        if (IFIDWrite) begin m_iv <= 0; m_ii <= 0; end
        if (imem_valid) begin m_out <= 0; m_stale <= 0; end
      end else if (imem_valid) begin
        m_out <= 0;
        if (IFIDWrite) begin
          m_ii <= imem_rdata; m_ip <= m_pc; m_iv <= 1;
          if (PCWrite) m_pc <= m_pc + 1;
        end else begin
          m_held <= 1; m_hi <= imem_rdata; m_hp <= m_pc;
        end
      end else if (IFIDWrite) begin
        m_iv <= 0; m_ii <= 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("mdl_req", imem_req, !rst && !m_out && !m_held);
        chk("mdl_addr", imem_addr, m_pc);
        chk("mdl_ifid_valid", ifid_valid, m_iv);
        chk("mdl_ifid_instr", ifid_instr, m_ii);
        chk("mdl_ifid_pc", ifid_pc, m_ip);
`ifdef IF_FLUSH_CNT_EN
        chk("mdl_flush_count", flush_count, m_fc);
`endif
      end
    end
  end

  task automatic to_n(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    PCWrite = 1; IFIDWrite = 1; branch_taken = 0; branch_target = '0; rst = 1; lat = 1;
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    #1 rst = 0; cyc = -1;
    // zero-wait streaming from RESET_PC
    to_n(0);  chk("t1_req", imem_req, 1); chk("t1_addr", imem_addr, 16'h0010);
    to_n(1);  chk("t1_first_invalid", ifid_valid, 0);
    to_n(2);  chk("t1_pc10", ifid_pc, 16'h0010); chk("t1_i10", ifid_instr, 16'hA5B5); chk("t1_v10", ifid_valid, 1);
    to_n(4);  chk("t1_pc11", ifid_pc, 16'h0011); chk("t1_i11", ifid_instr, 16'hA5B4);
    to_n(6);  chk("t1_pc12", ifid_pc, 16'h0012); chk("t1_i12", ifid_instr, 16'hA5B7); chk("t1_addr13", imem_addr, 16'h0013);
    // stall across a response
    PCWrite = 0; IFIDWrite = 0;
    to_n(7);  chk("t2_hold7", ifid_pc, 16'h0012);
    to_n(8);  chk("t2_hold8", ifid_pc, 16'h0012); chk("t2_noreq8", imem_req, 0);
    to_n(9);  chk("t2_hold9", ifid_pc, 16'h0012); chk("t2_addr9", imem_addr, 16'h0013);
    PCWrite = 1; IFIDWrite = 1;
    to_n(10); chk("t2_pc13", ifid_pc, 16'h0013); chk("t2_i13", ifid_instr, 16'hA5B6); chk("t2_addr14", imem_addr, 16'h0014);
    to_n(11); lat = 3;
    to_n(12); chk("t2_pc14", ifid_pc, 16'h0014); chk("t2_i14", ifid_instr, 16'hA5B1);
    // redirect while a 3-cycle request is outstanding
    to_n(13); branch_taken = 1; branch_target = 16'h0040;
    to_n(14); branch_taken = 0;
    chk("t3_bubble", ifid_valid, 0); chk("t3_addr", imem_addr, 16'h0040); chk("t3_noreq", imem_req, 0);
    to_n(16); chk("t3_req40", imem_req, 1); chk("t3_addr40", imem_addr, 16'h0040); chk("t3_nostale", ifid_valid, 0);
    to_n(20); chk("t3_pc40", ifid_pc, 16'h0040); chk("t3_i40", ifid_instr, 16'hA5E5); chk("t3_v40", ifid_valid, 1);
    to_n(21); lat = 1;
    // redirect coinciding with a response while IF/ID is stalled
    to_n(25); chk("t4_pc41", ifid_pc, 16'h0041);
    branch_taken = 1; branch_target = 16'h0100; IFIDWrite = 0;
    to_n(26); branch_taken = 0; IFIDWrite = 1;
    chk("t4_req", imem_req, 1); chk("t4_addr", imem_addr, 16'h0100); chk("t4_bubble", ifid_valid, 0);
    to_n(28); chk("t4_pc100", ifid_pc, 16'h0100); chk("t4_i100", ifid_instr, 16'hA4A5);
    // PC wrap
    branch_taken = 1; branch_target = 16'hFFFF;
    to_n(29); branch_taken = 0; chk("t5_addr", imem_addr, 16'hFFFF); chk("t5_drop", imem_req, 0);
    to_n(30); chk("t5_req", imem_req, 1);
    to_n(32); chk("t5_pcFFFF", ifid_pc, 16'hFFFF); chk("t5_iFFFF", ifid_instr, 16'h5A5A); chk("t5_wrap", imem_addr, 16'h0000);
    // PCWrite=0 on delivery refetches the same address
    PCWrite = 0;
    to_n(34); chk("t6_pc0", ifid_pc, 16'h0000); chk("t6_i0", ifid_instr, 16'hA5A5); chk("t6_refetch", imem_addr, 16'h0000);
    PCWrite = 1;
    to_n(36); chk("t6_pc0b", ifid_pc, 16'h0000); chk("t6_addr1", imem_addr, 16'h0001);
`ifdef IF_FLUSH_CNT_EN
    chk("t7_flush3", flush_count, 3);
`endif
    // asynchronous reset mid-fetch
    to_n(37); #2 rst = 1; #1;
    chk("t7_rst_req", imem_req, 0); chk("t7_rst_valid", ifid_valid, 0);
    chk("t7_rst_instr", ifid_instr, 0); chk("t7_rst_pc", ifid_pc, 0); chk("t7_rst_addr", imem_addr, 16'h0010);
`ifdef IF_FLUSH_CNT_EN
    chk("t7_rst_flush", flush_count, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 0; cyc = -1;
    to_n(0); chk("t7_req", imem_req, 1); chk("t7_addr", imem_addr, 16'h0010);
    to_n(2); chk("t7_pc10", ifid_pc, 16'h0010); chk("t7_v10", ifid_valid, 1);
    // mixed stalls, redirects and latencies, checked by the model
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      PCWrite = ($urandom_range(0, 3) != 0);
      IFIDWrite = ($urandom_range(0, 3) != 0);
      branch_taken = !branch_taken && ($urandom_range(0, 9) == 0);
      branch_target = 16'($urandom);
      lat = $urandom_range(1, 3);
    end
    @(negedge clk);
    branch_taken = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
